// File: rtl/pc_it.sv
// ---------------------------------------------------------------------------
// pc_it -- fetch-address (IT) stage at the head of the single-issue pipeline.
//
// Holds the architectural fetch PC and picks the next one. The sources, in
// order of priority, are: reset, exception/eret flush, branch redirect,
// pending (deferred) branch, and the sequential PC + 4. It translates the
// virtual PC to a physical SRAM address and flags misaligned fetches
// (AdEL). The virtual PC, the valid bit and the exception vector go to IC on
// it_to_ic_bus.
//
// Ports
//   clk              in   1   clock, rising edge
//   rst              in   1   synchronous active-high reset
//   stall            in   6   stall vector; stall[0] = 1 holds this stage
//   flush            in   1   exception / eret redirect request
//   new_pc           in  32   redirect target, valid with flush
//   br_bus           in  33   {br_e, br_addr[31:0]} from EX
//   it_to_ic_bus     out 65   {excepttype[31:0], ce, pc[31:0]}
//   inst_sram_en     out  1   instruction SRAM read enable
//   inst_sram_wen    out  4   always zero (fetch never writes)
//   inst_sram_addr   out 32   physical fetch address
//   inst_sram_wdata  out 32   always zero
//
// All outputs depend only on registers. There is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module pc_it #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_INIT  = 32'hBFBF_FFFC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic [32:0] br_bus,
    output logic [64:0] it_to_ic_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [31:0] r_pc;
    logic        r_ce;
    logic        r_pend_v;
    logic [31:0] r_pend_addr;

    // -----------------------------------------------------------------------
    // Input decode
    // -----------------------------------------------------------------------
    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic        w_stop;
    logic [4:0]  w_unused_stall;

    assign w_br_e         = br_bus[32];
    assign w_br_addr      = br_bus[31:0];
    assign w_stop         = stall[0];
    // Downstream stall bits belong to later stages. This stage ignores them.
    assign w_unused_stall = stall[5:1];

    // -----------------------------------------------------------------------
    // Next-state selection
    // -----------------------------------------------------------------------
    logic [31:0] w_pc_next;
    logic        w_pend_v_next;
    logic [31:0] w_pend_addr_next;

    always_comb begin
        w_pc_next        = r_pc + 32'd4;   // 32-bit wrap intended
        w_pend_v_next    = r_pend_v;
        w_pend_addr_next = r_pend_addr;

        if (flush) begin
            // A flush beats both a branch and a stall. It also drops any
            // branch that is still waiting to be applied.
            w_pc_next     = new_pc;
            w_pend_v_next = 1'b0;
        end else if (w_br_e && !w_stop) begin
            w_pc_next     = w_br_addr;
            w_pend_v_next = 1'b0;
        end else if (w_br_e && w_stop) begin
            // Keep the branch until the stall lifts. A newer branch
            // replaces an older one that has not been taken yet.
            w_pc_next        = r_pc;
            w_pend_v_next    = 1'b1;
            w_pend_addr_next = w_br_addr;
        end else if (w_stop) begin
            w_pc_next = r_pc;
        end else if (r_pend_v) begin
            w_pc_next     = r_pend_addr;
            w_pend_v_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= PC_INIT;
            r_ce        <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'd0;
        end else begin
            r_pc        <= w_pc_next;
            r_ce        <= 1'b1;
            r_pend_v    <= w_pend_v_next;
            r_pend_addr <= w_pend_addr_next;
        end
    end

    // -----------------------------------------------------------------------
    // Address translation: kseg0/kseg1 map to the low 512 MB. Every other
    // segment passes through unchanged.
    // -----------------------------------------------------------------------
    logic [31:0] w_paddr;

    assign w_paddr = (r_pc[31:30] == 2'b10) ? {3'b000, r_pc[28:0]} : r_pc;

    // -----------------------------------------------------------------------
    // Exception detection: a fetch from a non-word-aligned address raises
    // AdEL. The check is gated by ce, so the reset value of the PC cannot
    // raise it.
    // -----------------------------------------------------------------------
    logic        w_adel;
    logic [31:0] w_excepttype;

    assign w_adel       = r_ce && (r_pc[1:0] != 2'b00);
    assign w_excepttype = {27'd0, w_adel, 4'd0};

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign inst_sram_en    = r_ce && !w_adel;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = w_paddr;
    assign inst_sram_wdata = 32'd0;
    assign it_to_ic_bus    = {w_excepttype, r_ce, r_pc};

endmodule

// File: tb/tb_pc_it.sv
// ---------------------------------------------------------------------------
// tb_pc_it -- directed bench for the fetch-address stage pc_it.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled at the
// same point, after the register update has settled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pc_it;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [32:0] br_bus;
    logic [64:0] it_to_ic_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    int n_checks = 0;
    int n_errors = 0;

    pc_it dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .br_bus          (br_bus),
        .it_to_ic_bus    (it_to_ic_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Checks one transaction: pc field, ce bit, excepttype, SRAM enable and
    // SRAM address.
    task automatic expect_out(input string tag, input logic [31:0] pc, input logic ce,
                              input logic [31:0] exc, input logic en, input logic [31:0] addr);
        check({tag, ".pc"},   {32'd0, it_to_ic_bus[31:0]},  {32'd0, pc});
        check({tag, ".ce"},   {63'd0, it_to_ic_bus[32]},    {63'd0, ce});
        check({tag, ".exc"},  {32'd0, it_to_ic_bus[64:33]}, {32'd0, exc});
        check({tag, ".en"},   {63'd0, inst_sram_en},        {63'd0, en});
        check({tag, ".addr"}, {32'd0, inst_sram_addr},      {32'd0, addr});
    endtask

    task automatic set_br(input logic e, input logic [31:0] a);
        br_bus = {e, a};
    endtask

    initial begin
        rst = 1'b1; stall = 6'd0; flush = 1'b0; new_pc = 32'd0; br_bus = 33'd0;

        // Reset held for three cycles.
        step; step; step;
        expect_out("reset", 32'hBFBF_FFFC, 1'b0, 32'd0, 1'b0, 32'h1FBF_FFFC);
        check("reset.wen",   {60'd0, inst_sram_wen}, 64'd0);
        check("reset.wdata", {32'd0, inst_sram_wdata}, 64'd0);

        // Reset release: sequential fetch from the boot vector.
        rst = 1'b0;
        step; expect_out("boot0", 32'hBFC0_0000, 1'b1, 32'd0, 1'b1, 32'h1FC0_0000);
        step; expect_out("boot1", 32'hBFC0_0004, 1'b1, 32'd0, 1'b1, 32'h1FC0_0004);
        step; expect_out("boot2", 32'hBFC0_0008, 1'b1, 32'd0, 1'b1, 32'h1FC0_0008);
        step; step;
        check("seq.pc10", {32'd0, it_to_ic_bus[31:0]}, 64'hBFC0_0010);

        // Branch with no stall.
        set_br(1'b1, 32'hBFC0_0100);
        step; expect_out("br", 32'hBFC0_0100, 1'b1, 32'd0, 1'b1, 32'h1FC0_0100);
        set_br(1'b0, 32'd0);
        step; expect_out("br+4", 32'hBFC0_0104, 1'b1, 32'd0, 1'b1, 32'h1FC0_0104);

        // Branch during a stall: PC holds for three cycles, then the
        // pending target is taken.
        stall = 6'b000001; set_br(1'b1, 32'h8000_1000);
        step; expect_out("stall1", 32'hBFC0_0104, 1'b1, 32'd0, 1'b1, 32'h1FC0_0104);
        set_br(1'b0, 32'd0);
        step; expect_out("stall2", 32'hBFC0_0104, 1'b1, 32'd0, 1'b1, 32'h1FC0_0104);
        step; expect_out("stall3", 32'hBFC0_0104, 1'b1, 32'd0, 1'b1, 32'h1FC0_0104);
        stall = 6'd0;
        step; expect_out("pend", 32'h8000_1000, 1'b1, 32'd0, 1'b1, 32'h0000_1000);
        step; expect_out("pend+4", 32'h8000_1004, 1'b1, 32'd0, 1'b1, 32'h0000_1004);

        // Flush and branch in the same cycle while a branch is pending.
        // The flush target wins and the pending branch is dropped.
        stall = 6'b000001; set_br(1'b1, 32'h8000_2000);
        step; expect_out("pendset", 32'h8000_1004, 1'b1, 32'd0, 1'b1, 32'h0000_1004);
        flush = 1'b1; new_pc = 32'hBFC0_0380; set_br(1'b1, 32'hBFC0_0200);
        step; expect_out("flush", 32'hBFC0_0380, 1'b1, 32'd0, 1'b1, 32'h1FC0_0380);
        flush = 1'b0; set_br(1'b0, 32'd0); stall = 6'd0;
        step; expect_out("flush+4", 32'hBFC0_0384, 1'b1, 32'd0, 1'b1, 32'h1FC0_0384);
        step; check("flush+8.pc", {32'd0, it_to_ic_bus[31:0]}, 64'hBFC0_0388);

        // A fresh branch replaces a pending one.
        stall = 6'b000001; set_br(1'b1, 32'h8000_3000);
        step; check("sup.hold", {32'd0, it_to_ic_bus[31:0]}, 64'hBFC0_0388);
        stall = 6'd0; set_br(1'b1, 32'h8000_4000);
        step; check("sup.new", {32'd0, it_to_ic_bus[31:0]}, 64'h8000_4000);
        set_br(1'b0, 32'd0);
        step; check("sup.next", {32'd0, it_to_ic_bus[31:0]}, 64'h8000_4004);

        // Misaligned fetch raises AdEL.
        set_br(1'b1, 32'h0040_0002);
        step; expect_out("misal", 32'h0040_0002, 1'b1, 32'h0000_0010, 1'b0, 32'h0040_0002);
        set_br(1'b0, 32'd0);
        step; check("misal+4.pc", {32'd0, it_to_ic_bus[31:0]}, 64'h0040_0006);

        // Wrap from the top of the address space into kuseg.
        flush = 1'b1; new_pc = 32'hFFFF_FFFC;
        step; expect_out("top", 32'hFFFF_FFFC, 1'b1, 32'd0, 1'b1, 32'hFFFF_FFFC);
        flush = 1'b0;
        step; expect_out("wrap", 32'h0000_0000, 1'b1, 32'd0, 1'b1, 32'h0000_0000);

        // Reset with a branch pending and a flush asserted: both are
        // ignored, and fetch restarts at the boot vector.
        stall = 6'b000001; set_br(1'b1, 32'h8000_5000);
        step;
        rst = 1'b1; set_br(1'b0, 32'd0); flush = 1'b1; new_pc = 32'h1234_5678;
        step; expect_out("rst2", 32'hBFBF_FFFC, 1'b0, 32'd0, 1'b0, 32'h1FBF_FFFC);
        rst = 1'b0; flush = 1'b0; stall = 6'd0;
        step; expect_out("reboot", 32'hBFC0_0000, 1'b1, 32'd0, 1'b1, 32'h1FC0_0000);
        step; check("reboot+4.pc", {32'd0, it_to_ic_bus[31:0]}, 64'hBFC0_0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
